// File: rtl/vga_text_pkg.sv
// Shared character codes, colours and row tables for the VGA text overlay.
// Label and separator tables are indexed by display row.
package vga_text_pkg;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_DASH  = 8'h2D;
    localparam logic [7:0] CH_SLASH = 8'h2F;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_GLYPH = 8'h06;

    localparam logic [2:0] COL_BLACK  = 3'b000;
    localparam logic [2:0] COL_LABEL  = 3'b010;
    localparam logic [2:0] COL_DIGIT  = 3'b111;
    localparam logic [2:0] COL_CURSOR = 3'b001;
    localparam logic [2:0] COL_ALARM  = 3'b001;
    localparam logic [2:0] COL_GLYPH  = 3'b111;

    localparam logic [0:3][39:0] LABEL = {"FECHA", "HORA ", "TIMER", "ALARM"};
    localparam logic [0:3][7:0]  SEP   = {CH_SLASH, CH_COLON, CH_COLON, CH_COLON};

    typedef enum logic [1:0] {
        RG_NONE,
        RG_LABEL,
        RG_DIGIT,
        RG_GLYPH
    } region_e;

    typedef struct packed {
        logic [2:0] bit_sel;
        logic [2:0] fg;
        logic [2:0] bg;
        logic       in_region;
        logic       vid;
    } pix_stage_t;

    function automatic logic [7:0] bcd_char(input logic [3:0] nib);
        return (nib > 4'd9) ? CH_DASH : {4'h3, nib};
    endfunction

    function automatic logic [7:0] label_char(input logic [1:0] r,
                                              input logic [2:0] i);
        logic [39:0] s;
        s = LABEL[r] << {i, 3'b000};
        return s[39:32];
    endfunction

    function automatic logic [7:0] sep_char(input logic [1:0] r);
        return SEP[r];
    endfunction

endpackage

// File: rtl/font_rom.sv
// Synchronous 128-char x 16-row font; glyphs occupy rows 4..10 of each cell.
// Only the characters used by the overlay carry bitmaps; the rest read blank.
module font_rom (
    input  logic        clk,
    input  logic [10:0] addr,
    output logic [7:0]  data
);

    logic [55:0] g;
    logic [3:0]  row;
    logic [7:0]  d;

    assign row = addr[3:0];

    always_comb begin
        g = 56'h0;
        case (addr[10:4])
            7'h06: g = 56'h183C3C3C7EFF18;
            7'h2D: g = 56'h0000007E000000;
            7'h2F: g = 56'h060C0C18303060;
            7'h30: g = 56'h3C666E7666663C;
            7'h31: g = 56'h1838181818187E;
            7'h32: g = 56'h3C66060C18307E;
            7'h33: g = 56'h3C66061C06663C;
            7'h34: g = 56'h0C1C3C6C7E0C0C;
            7'h35: g = 56'h7E607C0606663C;
            7'h36: g = 56'h3C607C6666663C;
            7'h37: g = 56'h7E060C18303030;
            7'h38: g = 56'h3C66663C66663C;
            7'h39: g = 56'h3C66663E060C38;
            7'h3A: g = 56'h00181800181800;
            7'h41: g = 56'h183C66667E6666;
            7'h43: g = 56'h3C66606060663C;
            7'h45: g = 56'h7E60607C60607E;
            7'h46: g = 56'h7E60607C606060;
            7'h48: g = 56'h6666667E666666;
            7'h49: g = 56'h3C18181818183C;
            7'h4C: g = 56'h6060606060607E;
            7'h4D: g = 56'h63777F6B636363;
            7'h4F: g = 56'h3C66666666663C;
            7'h52: g = 56'h7C66667C786C66;
            7'h54: g = 56'h7E181818181818;
            default: g = 56'h0;
        endcase
    end

    always_comb begin
        d = 8'h00;
        if (row >= 4'd4 && row <= 4'd10)
            d = 8'(g >> {3'(4'd10 - row), 3'b000});
    end

    always_ff @(posedge clk) begin
        data <= d;
    end

endmodule

// File: rtl/vga_text_overlay_blink_gen.sv
// Free-running blink phase: toggles once every DIV clock cycles.
// Shared by display blocks that need a common blink cadence.
module blink_gen #(
    parameter int DIV = 12500000
) (
    input  logic CLK,
    input  logic RESET,
    output logic phase
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = (cnt == CW'(DIV - 1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (wrap) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/vga_text_overlay.sv
// Text overlay for RTC rows: labels, BCD digit fields with cursor, alarm glyph.
// Field data is snapshotted at frame start; output lags pixel input by 2 cycles.
module vga_text_overlay #(
    parameter int ROWS         = 3,
    parameter int ROW0         = 1,
    parameter int LABEL_COL    = 18,
    parameter int DIGIT_COL    = 8,
    parameter int SYM_ROW      = 9,
    parameter int SYM_COL      = 32,
    parameter int BLINK_DIV    = 12500000,
    parameter int CURSOR_BLINK = 0
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [9:0]          pix_x,
    input  logic [9:0]          pix_y,
    input  logic                video_on,
    input  logic [ROWS*24-1:0]  field_bcd,
    input  logic [ROWS*3-1:0]   cursor_en,
    input  logic                alarm_on,
    output logic                frame_load,
    output logic [2:0]          graph_rgb
);

    import vga_text_pkg::*;

    logic [ROWS*24-1:0] bcd_q;
    logic [ROWS*3-1:0]  cur_q;
    logic               snap_valid;
    logic               blink_phase;

    blink_gen #(
        .DIV (BLINK_DIV)
    ) u_blink (
        .CLK   (CLK),
        .RESET (RESET),
        .phase (blink_phase)
    );

    assign frame_load = !RESET && (pix_x == 10'd0) && (pix_y == 10'd0);

    // Drawing reads only these shadows, so a frame never mixes old and new data.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            bcd_q      <= '0;
            cur_q      <= '0;
            snap_valid <= 1'b0;
        end else if (frame_load) begin
            bcd_q      <= field_bcd;
            cur_q      <= cursor_en;
            snap_valid <= 1'b1;
        end
    end

    logic [5:0] col;
    logic [4:0] crow;
    logic [3:0] frow;
    logic       on_screen;
    logic       cur_ok;

    assign col       = pix_x[9:4];
    assign crow      = pix_y[9:5];
    assign frow      = pix_y[4:1];
    assign on_screen = (pix_x < 10'd640) && (pix_y < 10'd480);
    assign cur_ok    = (CURSOR_BLINK == 0) || blink_phase;

    region_e    rg;
    logic [6:0] char_c;
    logic [2:0] fg_c;
    logic [2:0] bg_c;

    always_comb begin
        rg     = RG_NONE;
        char_c = 7'(CH_SPACE);
        fg_c   = COL_BLACK;
        bg_c   = COL_BLACK;
        if (on_screen) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int i = 0; i < 5; i++) begin
                    if (rg == RG_NONE &&
                        int'(crow) == ROW0 + 2*r &&
                        int'(col) == LABEL_COL + i) begin
                        rg     = RG_LABEL;
                        char_c = 7'(label_char(2'(r), 3'(i)));
                        fg_c   = COL_LABEL;
                    end
                end
            end
            for (int r = 0; r < ROWS; r++) begin
                for (int j = 0; j < 3; j++) begin
                    for (int d = 0; d < 2; d++) begin
                        if (rg == RG_NONE &&
                            int'(crow) == ROW0 + 2*r + 1 &&
                            int'(col) == DIGIT_COL + 3*j + d) begin
                            rg     = RG_DIGIT;
                            char_c = 7'(bcd_char(
                                bcd_q[(3*r+j)*8 + 4*(1-d) +: 4]));
                            fg_c   = COL_DIGIT;
                            if (cur_q[3*r+j] && cur_ok)
                                bg_c = COL_CURSOR;
                        end
                    end
                    if (j < 2 && rg == RG_NONE &&
                        int'(crow) == ROW0 + 2*r + 1 &&
                        int'(col) == DIGIT_COL + 3*j + 2) begin
                        rg     = RG_DIGIT;
                        char_c = 7'(sep_char(2'(r)));
                        fg_c   = COL_DIGIT;
                    end
                end
            end
            if (rg == RG_NONE &&
                int'(crow) == SYM_ROW &&
                int'(col) == SYM_COL) begin
                rg     = RG_GLYPH;
                char_c = 7'(CH_GLYPH);
                fg_c   = (alarm_on && blink_phase) ? COL_ALARM : COL_GLYPH;
            end
        end
    end

    // The ROM's registered read is the stage-1 address register.
    logic [10:0] rom_addr;
    logic [7:0]  rom_data;

    assign rom_addr = {char_c, frow};

    font_rom u_font (
        .clk  (CLK),
        .addr (rom_addr),
        .data (rom_data)
    );

    pix_stage_t st1;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            st1 <= '0;
        end else begin
            st1.bit_sel   <= pix_x[3:1];
            st1.fg        <= fg_c;
            st1.bg        <= bg_c;
            st1.in_region <= (rg != RG_NONE);
            st1.vid       <= video_on && snap_valid;
        end
    end

    logic font_bit;

    assign font_bit = rom_data[~st1.bit_sel];

    always_ff @(posedge CLK) begin
        if (RESET)
            graph_rgb <= COL_BLACK;
        else if (!st1.vid)
            graph_rgb <= COL_BLACK;
        else if (font_bit)
            graph_rgb <= st1.fg;
        else if (st1.in_region)
            graph_rgb <= st1.bg;
        else
            graph_rgb <= COL_BLACK;
    end

endmodule

// File: tb/tb_vga_text_overlay.sv
// Directed bench for vga_text_overlay with hand-computed pixel colours.
// Fast blink (BLINK_DIV=4) so the alarm glyph cadence is observable.
module tb_vga_text_overlay;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic        video_on = 1'b1;
    logic [71:0] field_bcd = {48'h0, 8'h00, 8'h4A, 8'h23};
    logic [8:0]  cursor_en = '0;
    logic        alarm_on = 1'b0;
    logic        frame_load;
    logic [2:0]  graph_rgb;

    int tests = 0;
    int fails = 0;

    vga_text_overlay #(
        .BLINK_DIV (4)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .video_on   (video_on),
        .field_bcd  (field_bcd),
        .cursor_en  (cursor_en),
        .alarm_on   (alarm_on),
        .frame_load (frame_load),
        .graph_rgb  (graph_rgb)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic show(input int x, input int y);
        pix_x = 10'(x);
        pix_y = 10'(y);
        tick(2);
    endtask

    task automatic snap();
        pix_x = '0;
        pix_y = '0;
        #1;
        chk("frame_load_origin", {7'b0, frame_load}, 8'd1);
        tick(1);
    endtask

    logic [2:0] v, other, first;
    logic       found;

    initial begin
        tick(3);
        chk("reset_rgb", {5'b0, graph_rgb}, 8'h0);
        chk("reset_frame_load", {7'b0, frame_load}, 8'h0);

        pix_x = 10'd132;
        pix_y = 10'd72;
        RESET = 1'b0;
        tick(3);
        chk("pre_snapshot_black", {5'b0, graph_rgb}, 8'h0);

        snap();
        pix_x = 10'd1;
        #1;
        chk("frame_load_off_origin", {7'b0, frame_load}, 8'h0);

        // '2' font row 4 = 3C; bit 2 lit, then a blank pixel
        pix_x = 10'd132;
        pix_y = 10'd72;
        tick(1);
        pix_x = 10'd0;
        pix_y = 10'd300;
        tick(1);
        chk("latency_digit2", {5'b0, graph_rgb}, 8'h7);
        tick(1);
        chk("latency_blank", {5'b0, graph_rgb}, 8'h0);

        show(130, 72);
        chk("digit2_bit1", {5'b0, graph_rgb}, 8'h0);
        show(128, 72);
        chk("digit2_bit0", {5'b0, graph_rgb}, 8'h0);

        show(290, 40);
        chk("label_F", {5'b0, graph_rgb}, 8'h2);
        show(290, 104);
        chk("label_H", {5'b0, graph_rgb}, 8'h2);
        show(290, 232);
        chk("beyond_rows", {5'b0, graph_rgb}, 8'h0);

        video_on = 1'b0;
        show(132, 72);
        chk("video_off", {5'b0, graph_rgb}, 8'h0);
        video_on = 1'b1;

        show(182, 78);
        chk("digit4_bit3", {5'b0, graph_rgb}, 8'h0);
        show(178, 78);
        chk("digit4_bit1", {5'b0, graph_rgb}, 8'h7);
        show(198, 78);
        chk("dash_mid", {5'b0, graph_rgb}, 8'h7);
        show(198, 72);
        chk("dash_top", {5'b0, graph_rgb}, 8'h0);

        field_bcd[7:0] = 8'h53;
        show(130, 72);
        chk("midframe_hold", {5'b0, graph_rgb}, 8'h0);
        snap();
        show(130, 72);
        chk("after_snapshot", {5'b0, graph_rgb}, 8'h7);

        cursor_en = 9'b000000100;
        snap();
        show(224, 64);
        chk("cursor_k6", {5'b0, graph_rgb}, 8'h1);
        show(240, 64);
        chk("cursor_k7", {5'b0, graph_rgb}, 8'h1);
        show(208, 64);
        chk("cursor_sep", {5'b0, graph_rgb}, 8'h0);
        show(192, 64);
        chk("cursor_k4", {5'b0, graph_rgb}, 8'h0);
        show(224, 128);
        chk("cursor_row1", {5'b0, graph_rgb}, 8'h0);

        show(700, 72);
        chk("offscreen_x", {5'b0, graph_rgb}, 8'h0);
        show(1023, 1023);
        chk("offscreen_xy", {5'b0, graph_rgb}, 8'h0);

        // bell glyph font row 9 = FF
        alarm_on = 1'b1;
        show(512, 306);
        first = graph_rgb;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick(1);
            if (graph_rgb !== first)
                found = 1'b1;
        end
        chk("blink_edge_seen", {7'b0, found}, 8'h1);
        v = graph_rgb;
        other = (v == 3'b001) ? 3'b111 : 3'b001;
        chk("blink_colour_valid",
            {7'b0, (v == 3'b001 || v == 3'b111)}, 8'h1);
        for (int i = 1; i < 12; i++) begin
            tick(1);
            chk($sformatf("blink_%0d", i), {5'b0, graph_rgb},
                {5'b0, ((i / 4) % 2 == 0) ? v : other});
        end

        alarm_on = 1'b0;
        tick(2);
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk($sformatf("glyph_steady_%0d", i), {5'b0, graph_rgb}, 8'h7);
        end

        show(132, 72);
        chk("pre_reset_lit", {5'b0, graph_rgb}, 8'h7);
        RESET = 1'b1;
        pix_x = '0;
        pix_y = '0;
        tick(3);
        chk("midreset_rgb", {5'b0, graph_rgb}, 8'h0);
        chk("midreset_frame_load", {7'b0, frame_load}, 8'h0);
        pix_x = 10'd132;
        pix_y = 10'd72;
        RESET = 1'b0;
        tick(3);
        chk("post_reset_black", {5'b0, graph_rgb}, 8'h0);
        snap();
        show(132, 72);
        chk("post_reset_snapshot", {5'b0, graph_rgb}, 8'h7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
